// File: rtl/uart_rx_majority_sampler.sv
// Oversampling majority-vote bit sampler for the UART receiver.
// Ports: i_clk/i_reset (async, active high), i_rx_in serial line,
// i_data_samp_en enable, i_Prescale ratio, i_edge_cnt bit position;
// o_sample_bit voted bit, o_sample_valid 1-cycle strobe,
// o_noise_flag non-unanimous samples, o_cfg_err illegal prescale.
module uart_rx_majority_sampler #(
  parameter int PRESCALE_W   = 7,
  parameter int NUM_SAMPLES  = 3,
  parameter int MIN_PRESCALE = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_rx_in,
  input  logic                  i_data_samp_en,
  input  logic [PRESCALE_W-1:0] i_Prescale,
  input  logic [PRESCALE_W-1:0] i_edge_cnt,
  output logic                  o_sample_bit,
  output logic                  o_sample_valid,
  output logic                  o_noise_flag,
  output logic                  o_cfg_err
);

  localparam int H  = (NUM_SAMPLES - 1) / 2;
  localparam int AW = PRESCALE_W + 1;
  localparam int CW = $clog2(NUM_SAMPLES + 1);

  generate
    if (NUM_SAMPLES < 1 || NUM_SAMPLES > 7 ||
        (NUM_SAMPLES % 2) == 0) begin : g_bad_num
      $error("NUM_SAMPLES must be odd and in 1..7");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE,
    SAMPLE,
    DECIDE
  } state_t;

  state_t                 state;
  logic [NUM_SAMPLES-1:0] shreg;
  logic [CW-1:0]          cnt;

  logic [AW-1:0]          presc;
  logic [AW-1:0]          edge_w;
  logic [AW-1:0]          mid;
  logic [AW-1:0]          first;
  logic [NUM_SAMPLES-1:0] sh_next;
  logic [CW-1:0]          cnt_next;
  logic [CW-1:0]          ones;
  logic                   take;
  logic                   last_cap;

  assign presc  = {1'b0, i_Prescale};
  assign edge_w = {1'b0, i_edge_cnt};
  assign mid    = (presc >> 1) - AW'(1);
  assign first  = mid - AW'(H);

  assign o_cfg_err = i_Prescale[0] |
                     (presc < AW'(MIN_PRESCALE)) |
                     (presc < AW'(2 * (H + 1)));

  always_comb begin
    take     = 1'b0;
    sh_next  = NUM_SAMPLES'(i_rx_in);
    cnt_next = CW'(1);
    last_cap = (NUM_SAMPLES == 1);
    ones     = '0;
    unique case (state)
      IDLE: begin
        take = i_data_samp_en && (edge_w == first);
      end
      SAMPLE: begin
        // Each capture must land exactly on FIRST+count;
        // anything else means the edge counter moved under us.
        take     = i_data_samp_en &&
                   (edge_w == first + AW'(cnt));
        sh_next  = (shreg << 1) | NUM_SAMPLES'(i_rx_in);
        cnt_next = cnt + CW'(1);
        last_cap = (cnt == CW'(NUM_SAMPLES - 1));
      end
      default: begin
        take = 1'b0;
      end
    endcase
    for (int i = 0; i < NUM_SAMPLES; i++) begin
      ones = ones + CW'(sh_next[i]);
    end
  end

  // The vote is taken on the final capture edge so the strobe
  // is visible in the DECIDE cycle (edge count LAST+1).
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      shreg          <= '0;
      cnt            <= '0;
      o_sample_bit   <= 1'b1;
      o_sample_valid <= 1'b0;
      o_noise_flag   <= 1'b0;
    end else begin
      o_sample_valid <= 1'b0;
      if (o_cfg_err) begin
        state <= IDLE;
      end else if (take) begin
        shreg <= sh_next;
        cnt   <= cnt_next;
        if (last_cap) begin
          state          <= DECIDE;
          o_sample_bit   <= (ones > CW'(H));
          o_noise_flag   <= (ones != '0) &&
                            (ones != CW'(NUM_SAMPLES));
          o_sample_valid <= 1'b1;
        end else begin
          state <= SAMPLE;
        end
      end else begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_majority_sampler.sv
// Bench for uart_rx_majority_sampler: NUM_SAMPLES=3 and =5
// instances driven in parallel, checked against a window model.
module tb_uart_rx_majority_sampler;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       en;
  logic [6:0] presc;
  logic [6:0] edge_c;
  logic [1:0] sbit;
  logic [1:0] svld;
  logic [1:0] snoise;
  logic [1:0] serr;

  int total = 0;
  int bad   = 0;

  uart_rx_majority_sampler #(
    .PRESCALE_W(7), .NUM_SAMPLES(3), .MIN_PRESCALE(4)
  ) u_n3 (
    .i_clk(clk), .i_reset(rst), .i_rx_in(rx),
    .i_data_samp_en(en), .i_Prescale(presc),
    .i_edge_cnt(edge_c), .o_sample_bit(sbit[0]),
    .o_sample_valid(svld[0]), .o_noise_flag(snoise[0]),
    .o_cfg_err(serr[0])
  );

  uart_rx_majority_sampler #(
    .PRESCALE_W(7), .NUM_SAMPLES(5), .MIN_PRESCALE(4)
  ) u_n5 (
    .i_clk(clk), .i_reset(rst), .i_rx_in(rx),
    .i_data_samp_en(en), .i_Prescale(presc),
    .i_edge_cnt(edge_c), .o_sample_bit(sbit[1]),
    .o_sample_valid(svld[1]), .o_noise_flag(snoise[1]),
    .o_cfg_err(serr[1])
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic act,
                     input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic bit p_bad(input int p, input int n);
    int h;
    h = (n - 1) / 2;
    return (p % 2) != 0 || p < 4 || p < 2 * (h + 1);
  endfunction

  function automatic int first_of(input int p, input int n);
    return p / 2 - 1 - (n - 1) / 2;
  endfunction

  // Input history; index 0 is the most recent completed cycle.
  logic h_en  [8];
  logic h_rx  [8];
  logic h_rst [8];
  int   h_edge[8];
  int   h_p   [8];
  logic mbit  [2];
  logic mnoise[2];

  initial begin
    for (int k = 0; k < 8; k++) begin
      h_en[k] = 0; h_rx[k] = 1; h_rst[k] = 1;
      h_edge[k] = 0; h_p[k] = 8;
    end
    mbit[0] = 1; mbit[1] = 1;
    mnoise[0] = 0; mnoise[1] = 0;
  end

  // A decision is due now iff the last n cycles were n
  // consecutive legal enabled captures at FIRST..LAST.
  always @(negedge clk) begin
    int   n;
    int   ones;
    int   j;
    logic v;
    for (int i = 0; i < 2; i++) begin
      n    = (i == 0) ? 3 : 5;
      v    = 1'b1;
      ones = 0;
      for (int k = 0; k < n; k++) begin
        j = n - 1 - k;
        if (!h_en[j] || h_rst[j] || p_bad(h_p[j], n) ||
            h_edge[j] != first_of(h_p[j], n) + k)
          v = 1'b0;
        ones += int'(h_rx[j]);
      end
      if (rst) begin
        v = 1'b0;
        mbit[i] = 1'b1;
        mnoise[i] = 1'b0;
      end else if (v) begin
        mbit[i]   = (ones > (n - 1) / 2);
        mnoise[i] = (ones != 0) && (ones != n);
      end
      chk(i == 0 ? "n3_valid" : "n5_valid", svld[i], v);
      chk(i == 0 ? "n3_bit" : "n5_bit", sbit[i], mbit[i]);
      chk(i == 0 ? "n3_noise" : "n5_noise",
          snoise[i], mnoise[i]);
      chk(i == 0 ? "n3_cfg_err" : "n5_cfg_err", serr[i],
          logic'(p_bad(int'(presc), n)));
    end
    for (int k = 7; k > 0; k--) begin
      h_en[k] = h_en[k-1]; h_rx[k] = h_rx[k-1];
      h_rst[k] = h_rst[k-1]; h_edge[k] = h_edge[k-1];
      h_p[k] = h_p[k-1];
    end
    h_en[0] = en; h_rx[0] = rx; h_rst[0] = rst;
    h_edge[0] = int'(edge_c); h_p[0] = int'(presc);
  end

  // One bit period; rx follows rxv[edge]. Optional enable drop,
  // reset pulse, and literal check of instance li at lit_e.
  task automatic run_bit(input int p, input logic [31:0] rxv,
                         input int drop_e, input int rst_e,
                         input int lit_e, input int li,
                         input logic lv, input logic lb,
                         input logic ln);
    for (int e = 0; e < p; e++) begin
      @(posedge clk);
      #1;
      presc  = 7'(p);
      edge_c = 7'(e);
      rx     = rxv[e];
      en     = (e != drop_e);
      rst    = (e == rst_e);
      if (e == lit_e) begin
        #5;
        chk("lit_valid", svld[li], lv);
        chk("lit_bit", sbit[li], lb);
        chk("lit_noise", snoise[li], ln);
      end
    end
  endtask

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  initial begin
    rst = 1'b1; en = 1'b0; rx = 1'b1;
    presc = 7'd8; edge_c = 7'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_bit", sbit[0], 1'b1);
    chk("reset_valid", svld[0], 1'b0);
    chk("reset_noise", snoise[0], 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    // 1: all ones, p=8, strobe at edge 5
    run_bit(8, ONES, -1, -1, 5, 0, 1, 1, 0);
    // 3: p=32, n5 samples 1,1,0,1,0 at 13..17
    run_bit(32, 32'hFFFD_7FFF, -1, -1, 18, 1, 1, 1, 1);
    // 2: p=16, n3 samples 0,1,0 at 6..8
    run_bit(16, 32'hFFFF_FEBF, -1, -1, 9, 0, 1, 0, 1);
    // 4: enable drop at edge 7, previous decision held
    run_bit(16, ONES, 7, -1, 9, 0, 0, 0, 1);
    run_bit(16, ONES, -1, -1, 9, 0, 1, 1, 0);
    // 5: illegal prescale values
    run_bit(7, ONES, -1, -1, -1, 0, 0, 0, 0);
    chk("cfg_err_p7", serr[0], 1'b1);
    run_bit(2, ONES, -1, -1, -1, 0, 0, 0, 0);
    chk("cfg_err_p2", serr[0], 1'b1);
    run_bit(4, ONES, -1, -1, 3, 0, 1, 1, 0);
    chk("cfg_err_p4_n5", serr[1], 1'b1);
    run_bit(8, ONES, -1, -1, 5, 0, 1, 1, 0);
    chk("cfg_err_p8", serr[0], 1'b0);
    // 6: decide a zero, then reset mid-bit at edge 3
    run_bit(8, 32'hFFFF_FFE3, -1, -1, 5, 0, 1, 0, 0);
    run_bit(8, 32'h0, -1, 3, 3, 0, 0, 1, 0);
    run_bit(8, 32'h0, -1, -1, 5, 0, 1, 0, 0);
    run_bit(8, ONES, -1, -1, 5, 1, 0, 0, 0);
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_majority_sampler.md
Name: uart_rx_majority_sampler

Overview:
Parametrised oversampling bit sampler for the UART receiver. It captures NUM_SAMPLES consecutive samples of the serial line around the bit centre and resolves them by majority vote. It flags noisy bits and rejects unsupported prescale values. It sits between the edge/bit counter and the RX FSM/deserializer, which consume the one-cycle o_sample_valid strobe.

Parameters:
PRESCALE_W, 7, width of i_Prescale and i_edge_cnt; supports prescale up to 2^PRESCALE_W-2.
NUM_SAMPLES, 3, samples per bit; must be odd, 1..7; elaboration error otherwise.
MIN_PRESCALE, 4, smallest legal prescale.

Ports:
i_clk  in  1  oversampling clock; one edge-counter step per cycle.
i_reset  in  1  asynchronous, active-high reset.
i_rx_in  in  1  synchronised serial RX line.
i_data_samp_en  in  1  sampling enable from the RX FSM.
i_Prescale  in  PRESCALE_W  oversampling ratio; must be even, >= MIN_PRESCALE and >= 2*(H+1).
i_edge_cnt  in  PRESCALE_W  position within the current bit, 0..i_Prescale-1.
o_sample_bit  out  1  majority-voted bit value; holds until the next decision.
o_sample_valid  out  1  one-cycle strobe when o_sample_bit/o_noise_flag update.
o_noise_flag  out  1  samples of the last decided bit were not unanimous.
o_cfg_err  out  1  current i_Prescale is illegal; combinational from i_Prescale.

Behaviour:
- Definitions: H = (NUM_SAMPLES-1)/2; MID = i_Prescale/2 - 1; FIRST = MID-H; LAST = MID+H. Arithmetic is done in PRESCALE_W+1 bits, unsigned.
- o_cfg_err = 1 when i_Prescale is odd, < MIN_PRESCALE, or < 2*(H+1). While it is set, no capture occurs, o_sample_valid stays 0 and the FSM is forced to IDLE.
- Reset (async, i_reset=1): FSM=IDLE, sample shift register=0, sample count=0, o_sample_bit=1 (line idle level), o_sample_valid=0, o_noise_flag=0. Reset mid-bit discards any partial samples.
- FSM states: IDLE, SAMPLE, DECIDE.
  - IDLE -> SAMPLE when i_data_samp_en=1 and i_edge_cnt==FIRST. i_rx_in is captured in the same cycle (count=1).
  - SAMPLE: capture i_rx_in on every cycle with i_data_samp_en=1, count+1. When count reaches NUM_SAMPLES (the capture at i_edge_cnt==LAST), go to DECIDE.
  - SAMPLE -> IDLE (abort, no strobe) if i_data_samp_en drops, or if i_edge_cnt is not the expected FIRST+count value (counter resync or wrap).
  - DECIDE (single cycle): register o_sample_bit = 1 iff the ones count is > H. Register o_noise_flag = 1 iff the ones count is neither 0 nor NUM_SAMPLES. Pulse o_sample_valid=1. Return to IDLE.
- Latency: o_sample_valid is asserted in the cycle after the LAST capture, i.e. registered at i_edge_cnt==LAST+1 (<= i_Prescale-1, guaranteed by the legality rule).
- NUM_SAMPLES=1 case: FIRST=LAST=MID; SAMPLE is left immediately; o_noise_flag is always 0.
- i_Prescale changed mid-bit: the FSM compares against the new FIRST+count and aborts on mismatch. No partial decision is ever issued.
- i_data_samp_en low in IDLE: outputs hold their values; o_sample_valid=0.
- The sample shift register is NUM_SAMPLES bits and is cleared on entry to SAMPLE. The ones count is a popcount of these bits.
- One decision at most per bit period; back-to-back bits are supported with no dead cycles beyond the protocol spacing.

Test Plan:
1. Prescale=8, NUM_SAMPLES=3, rx=1 at edge_cnt 2,3,4 -> o_sample_valid pulse at edge_cnt 5, o_sample_bit=1, o_noise_flag=0.
2. Prescale=16, rx samples 0,1,0 at edge_cnt 6,7,8 -> o_sample_bit=0, o_noise_flag=1, single-cycle valid at edge_cnt 9.
3. NUM_SAMPLES=5, Prescale=32: samples 1,1,0,1,0 at edge_cnt 13..17 -> o_sample_bit=1, o_noise_flag=1, valid at edge_cnt 18.
4. Prescale=16, i_data_samp_en dropped at edge_cnt 7 -> no o_sample_valid for that bit; o_sample_bit retains its previous value; next full bit decides correctly.
5. i_Prescale=7, then 2 (NUM_SAMPLES=3) -> o_cfg_err=1, no valid strobes. i_Prescale=8 -> o_cfg_err=0 and normal operation resumes.
6. Assert i_reset at edge_cnt 3 of a Prescale=8 bit -> outputs return to o_sample_bit=1, valid=0, noise=0 asynchronously; no stale decision after release.
